// File: rtl/risc_lmsm_seq_if.sv
// Bus bundle for the load/store-multiple sequencer: command/status, register-file ports, memory port.
// Memory handshake: while mem_ren or mem_wen is high, mem_addr/mem_wdata/strobes stay frozen until the cycle mem_ready=1 completes the access.
interface risc_lmsm_seq_if #(
  parameter int DW   = 16,
  parameter int AW   = 6,
  parameter int NREG = 8,
  parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1
);
  logic            start;
  logic            is_store;
  logic [AW-1:0]   base_addr;
  logic [NREG-1:0] reg_mask;
  logic [RW-1:0]   base_reg;

  logic [RW-1:0]   rf_raddr;
  logic [DW-1:0]   rf_rdata;
  logic            rf_wen;
  logic [RW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;

  logic            mem_ren;
  logic            mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  logic            busy;
  logic            done;
  logic [RW:0]     xfer_count;

  modport master (
    input  start, is_store, base_addr, reg_mask, base_reg,
    input  rf_rdata, mem_rdata, mem_ready,
    output rf_raddr, rf_wen, rf_waddr, rf_wdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    output busy, done, xfer_count
  );

  modport slave (
    output start, is_store, base_addr, reg_mask, base_reg,
    output rf_rdata, mem_rdata, mem_ready,
    input  rf_raddr, rf_wen, rf_waddr, rf_wdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    input  busy, done, xfer_count
  );
endinterface

// File: rtl/risc_lmsm_seq.sv
// Load/store-multiple sequencer: walks a register mask lowest-bit first, one memory access per register.
// Optional macro LMSM_WRITEBACK_EN adds a WB state that writes the final address into base_reg.
module risc_lmsm_seq #(
  parameter int DW   = 16,
  parameter int AW   = 6,
  parameter int NREG = 8
) (
  input  logic                 clk,
  input  logic                 proc_rst,
  risc_lmsm_seq_if.master      bus,
  output logic [1:0]           state_dbg
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

`ifdef LMSM_WRITEBACK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DONE = 2'd2, S_WB = 2'd3} state_t;
  localparam state_t S_FIN = S_WB;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DONE = 2'd2} state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  state_t          state, state_nxt;
  logic [NREG-1:0] mask;
  logic [NREG-1:0] mask_clr;
  logic [AW-1:0]   addr_ptr;
  logic            is_store_q;
  logic [RW:0]     xfer_count;
  logic [RW-1:0]   idx;
`ifdef LMSM_WRITEBACK_EN
  logic [RW-1:0]   base_reg_q;
`endif

  // Lowest set bit wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask[i]) idx = RW'(i);
    end
  end

  assign mask_clr       = mask & ~({{(NREG-1){1'b0}}, 1'b1} << idx);
  assign bus.xfer_count = xfer_count;
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state      <= S_IDLE;
      mask       <= '0;
      addr_ptr   <= '0;
      is_store_q <= 1'b0;
      xfer_count <= '0;
`ifdef LMSM_WRITEBACK_EN
      base_reg_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.start) begin
        mask       <= bus.reg_mask;
        addr_ptr   <= bus.base_addr;
        is_store_q <= bus.is_store;
        xfer_count <= '0;
`ifdef LMSM_WRITEBACK_EN
        base_reg_q <= bus.base_reg;
`endif
      end else if (state == S_XFER && bus.mem_ready) begin
        mask       <= mask_clr;
        addr_ptr   <= addr_ptr + 1'b1;
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rf_raddr  = '0;
    bus.rf_wen    = 1'b0;
    bus.rf_waddr  = '0;
    bus.rf_wdata  = '0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = (bus.reg_mask == '0) ? S_FIN : S_XFER;
      end
      S_XFER: begin
        bus.mem_addr = addr_ptr;
        if (is_store_q) begin
          bus.mem_wen   = 1'b1;
          bus.rf_raddr  = idx;
          bus.mem_wdata = bus.rf_rdata;
        end else begin
          bus.mem_ren = 1'b1;
        end
        if (bus.mem_ready) begin
          if (!is_store_q) begin
            bus.rf_wen   = 1'b1;
            bus.rf_waddr = idx;
            bus.rf_wdata = bus.mem_rdata;
          end
          if (mask_clr == '0) state_nxt = S_FIN;
        end
      end
`ifdef LMSM_WRITEBACK_EN
      S_WB: begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = base_reg_q;
        bus.rf_wdata = DW'(addr_ptr);
        state_nxt    = S_DONE;
      end
`endif
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule
